// File: rtl/hazard_sched_pkg.sv
// Shared types for the hazard scheduler: the scoreboard entry layout, the control FSM
// states and the register-match rule used by every scoreboard slot.
package hazard_sched_pkg;

    localparam int REG_FILE_ADDR_LEN = 4;

    typedef struct packed {
        logic                         v;
        logic                         wb_en;
        logic                         mem_r_en;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } sched_state_e;

    // Register 0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic entry_match(sb_entry_t e, logic [REG_FILE_ADDR_LEN-1:0] s);
        return e.v & e.wb_en & (e.dest == s) & (s != '0);
    endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Decode-side bundle for the hazard scheduler: the decode instruction description going in,
// stall/flush control and debug counters coming out.
interface hazard_sched_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  use_src1;
    logic                  use_src2;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_wb_en;
    logic                  id_mem_r_en;
    logic                  br_taken;
    logic                  jump_en;
    logic                  fwd_en;

    logic                  hazard_detected;
    logic                  pc_freeze;
    logic                  if_id_flush;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic                  wdog_err;

    modport master (
        output id_valid, src1, src2, use_src1, use_src2, id_dest, id_wb_en, id_mem_r_en,
               br_taken, jump_en, fwd_en,
        input  hazard_detected, pc_freeze, if_id_flush, stall_cnt, flush_cnt, wdog_err
    );

    modport slave (
        input  id_valid, src1, src2, use_src1, use_src2, id_dest, id_wb_en, id_mem_r_en,
               br_taken, jump_en, fwd_en,
        output hazard_detected, pc_freeze, if_id_flush, stall_cnt, flush_cnt, wdog_err
    );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: holds an in-flight instruction's write-back target and reports,
// combinationally, whether either decode source depends on it.
module hazard_sb_entry
    import hazard_sched_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  sb_entry_t                    entry_d_i,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1_i,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2_i,
    output sb_entry_t                    entry_q_o,
    output logic                         match1_o,
    output logic                         match2_o
);

    sb_entry_t entry_q;

    // NOTE: the slot is reset rather than left to flush out; a stale valid bit after reset
    // would stall decode on garbage.
    // NOTE: non-blocking assignment so every pipeline register samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d_i;
        end
    end

    assign entry_q_o = entry_q;
    assign match1_o  = entry_match(entry_q, src1_i);
    assign match2_o  = entry_match(entry_q, src2_i);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: two-slot RAW scoreboard driving stall/freeze/flush for decode,
// plus saturating stall/flush counters and a consecutive-stall watchdog.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
    parameter int CNT_W      = 16,
    parameter int MAX_STALL  = 4
) (
    input logic           clk,
    input logic           rst,
    hazard_sched_if.slave bus
);

    localparam int               RUN_W     = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    sb_entry_t             exe_d;
    sb_entry_t             exe_q;
    sb_entry_t             mem_q_unused;
    logic                  exe_m1, exe_m2, mem_m1, mem_m2;
    logic                  raw_exe, raw_mem, hazard, flush;

    sched_state_e          state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  wdog_q, wdog_d;

    assign src1 = bus.src1;
    assign src2 = bus.src2;

    // A stalled instruction stays in decode, so EXE receives a bubble instead of it.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        exe_d = '0;
        if (!hazard) begin
            exe_d.v        = bus.id_valid;
            exe_d.wb_en    = bus.id_wb_en;
            exe_d.mem_r_en = bus.id_mem_r_en;
            exe_d.dest     = bus.id_dest;
        end
    end

    hazard_sb_entry u_exe (
        .clk       (clk),
        .rst       (rst),
        .entry_d_i (exe_d),
        .src1_i    (src1),
        .src2_i    (src2),
        .entry_q_o (exe_q),
        .match1_o  (exe_m1),
        .match2_o  (exe_m2)
    );

    // MEM contributes only through its match outputs; its raw contents are not consumed.
    hazard_sb_entry u_mem (
        .clk       (clk),
        .rst       (rst),
        .entry_d_i (exe_q),
        .src1_i    (src1),
        .src2_i    (src2),
        .entry_q_o (mem_q_unused),
        .match1_o  (mem_m1),
        .match2_o  (mem_m2)
    );

    assign raw_exe = (bus.use_src1 & exe_m1) | (bus.use_src2 & exe_m2);
    assign raw_mem = (bus.use_src1 & mem_m1) | (bus.use_src2 & mem_m2);

    // With forwarding only a load in EXE is too late to bypass; without it any in-flight writer is.
    assign hazard = bus.id_valid &
                    (bus.fwd_en ? (raw_exe & exe_q.mem_r_en) : (raw_exe | raw_mem));
    assign flush  = (bus.br_taken | bus.jump_en) & ~hazard;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        unique case (state_q)
            ST_STALL: begin
                if (hazard) begin
                    run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
                end else begin
                    state_d = flush ? ST_FLUSH : ST_RUN;
                    run_d   = '0;
                end
            end
            default: begin
                if (hazard) begin
                    state_d = ST_STALL;
                    run_d   = RUN_W'(1);
                end else begin
                    state_d = flush ? ST_FLUSH : ST_RUN;
                    run_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + CNT_W'(1);
        wdog_d = wdog_q | (run_d >= RUN_LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            run_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wdog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign bus.hazard_detected = hazard;
    assign bus.pc_freeze       = hazard;
    assign bus.if_id_flush     = flush;
    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;
    assign bus.wdog_err        = wdog_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: hand-derived vector table, directed watchdog/reset/
// saturation sequences, and randomized traffic against an instruction-level reference model.
module tb_hazard_sched;

    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;
    localparam int MAX_STALL = 2;
    localparam int NVEC      = 23;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_sched_if #(.REG_ADDR_W(4), .CNT_W(CNT_W)) bus ();

    hazard_sched #(.REG_ADDR_W(4), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       u1;
        logic       u2;
        logic [3:0] d;
        logic       wb;
        logic       ld;
        logic       br;
        logic       jmp;
        logic       fwd;
    } in_t;

    typedef struct {
        in_t  in;
        logic haz;
        logic fl;
        int   sc;
        int   fc;
        logic wd;
    } vec_t;

    // An instruction that has left decode: index 0 is one stage ahead, index 1 two stages.
    typedef struct {
        bit v;
        bit wb;
        bit ld;
        int dest;
    } instr_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    instr_t m_pipe[2];
    int     m_sc, m_fc, m_run;
    bit     m_wd;
    vec_t   tbl[NVEC];
    in_t    idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic in_t mk(logic v, int s1, int s2, logic u1, logic u2, int d,
                               logic wb, logic ld, logic br, logic jmp, logic fwd);
        in_t r;
        r.v = v;   r.s1 = 4'(s1); r.s2 = 4'(s2); r.u1 = u1; r.u2 = u2; r.d = 4'(d);
        r.wb = wb; r.ld = ld;     r.br = br;     r.jmp = jmp; r.fwd = fwd;
        return r;
    endfunction

    function automatic vec_t row(in_t in, logic haz, logic fl, int sc, int fc, logic wd);
        vec_t r;
        r.in = in; r.haz = haz; r.fl = fl; r.sc = sc; r.fc = fc; r.wd = wd;
        return r;
    endfunction

    task automatic drive(input in_t in);
        bus.id_valid    = in.v;
        bus.src1        = in.s1;
        bus.src2        = in.s2;
        bus.use_src1    = in.u1;
        bus.use_src2    = in.u2;
        bus.id_dest     = in.d;
        bus.id_wb_en    = in.wb;
        bus.id_mem_r_en = in.ld;
        bus.br_taken    = in.br;
        bus.jump_en     = in.jmp;
        bus.fwd_en      = in.fwd;
    endtask

    // Reference rule: decode must wait if an older writer of one of its sources cannot
    // hand the value over in time (only an adjacent load when forwarding is on).
    function automatic bit model_hazard(in_t in);
        bit h = 1'b0;
        if (!in.v) return 1'b0;
        for (int age = 0; age < 2; age++) begin
            instr_t e = m_pipe[age];
            bit     reads;
            if (in.fwd && (age != 0 || !e.ld)) continue;
            if (!e.v || !e.wb || e.dest == 0) continue;
            reads = (in.u1 && e.dest == int'(in.s1)) || (in.u2 && e.dest == int'(in.s2));
            if (reads) h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_edge(input in_t in, input bit h, input bit f);
        if (h && m_sc < CNT_MAX) m_sc++;
        if (f && m_fc < CNT_MAX) m_fc++;
        m_run = h ? m_run + 1 : 0;
        if (m_run >= MAX_STALL) m_wd = 1'b1;
        m_pipe[1] = m_pipe[0];
        if (h) m_pipe[0] = '{v: 1'b0, wb: 1'b0, ld: 1'b0, dest: 0};
        else   m_pipe[0] = '{v: in.v, wb: in.wb, ld: in.ld, dest: int'(in.d)};
    endtask

    task automatic model_reset();
        m_pipe[0] = '{v: 1'b0, wb: 1'b0, ld: 1'b0, dest: 0};
        m_pipe[1] = m_pipe[0];
        m_sc = 0; m_fc = 0; m_run = 0; m_wd = 1'b0;
    endtask

    // One decode cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic step(input in_t in, input string tag, output logic h_o, output logic f_o);
        bit mh, mf;
        @(negedge clk);
        drive(in);
        #1;
        mh  = model_hazard(in);
        mf  = (in.br || in.jmp) && !mh;
        h_o = bus.hazard_detected;
        f_o = bus.if_id_flush;
        check({tag, " hazard"}, bus.hazard_detected, mh);
        check({tag, " pc_freeze"}, bus.pc_freeze, mh);
        check({tag, " flush"}, bus.if_id_flush, mf);
        @(posedge clk);
        model_edge(in, mh, mf);
        #1;
        check({tag, " stall_cnt"}, bus.stall_cnt, m_sc);
        check({tag, " flush_cnt"}, bus.flush_cnt, m_fc);
        check({tag, " wdog_err"}, bus.wdog_err, m_wd);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " hazard"}, bus.hazard_detected, 0);
        check({tag, " pc_freeze"}, bus.pc_freeze, 0);
        check({tag, " flush"}, bus.if_id_flush, 0);
        check({tag, " stall_cnt"}, bus.stall_cnt, 0);
        check({tag, " flush_cnt"}, bus.flush_cnt, 0);
        check({tag, " wdog_err"}, bus.wdog_err, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
        #1;
        model_reset();
        check_cleared(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic  h, f;
        string t;
        in_t   rin;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst  = 1'b0;
        drive(idle);
        model_reset();

        //                 v s1 s2 u1 u2  d wb ld br jp fw   haz fl sc fc wd
        tbl[0]  = row(mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 1), 0, 0, 0, 0, 0);
        tbl[1]  = row(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1), 1, 0, 1, 0, 0);
        tbl[2]  = row(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 1), 0, 0, 1, 0, 0);
        tbl[3]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 1, 0, 0);
        tbl[4]  = row(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0), 0, 0, 1, 0, 0);
        tbl[5]  = row(mk(1, 2, 7, 1, 1, 6, 1, 0, 0, 0, 0), 1, 0, 2, 0, 0);
        tbl[6]  = row(mk(1, 2, 7, 1, 1, 6, 1, 0, 0, 0, 0), 1, 0, 3, 0, 1);
        tbl[7]  = row(mk(1, 2, 7, 1, 1, 6, 1, 0, 0, 0, 0), 0, 0, 3, 0, 1);
        tbl[8]  = row(mk(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0), 0, 0, 3, 0, 1);
        tbl[9]  = row(mk(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0), 0, 0, 3, 0, 1);
        tbl[10] = row(mk(1, 8, 9, 1, 1, 0, 0, 0, 1, 0, 0), 0, 1, 3, 1, 1);
        tbl[11] = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 3, 1, 1);
        tbl[12] = row(mk(1, 1, 1, 1, 0, 9, 1, 1, 0, 0, 1), 0, 0, 3, 1, 1);
        tbl[13] = row(mk(1, 9, 10, 1, 1, 0, 0, 0, 1, 0, 1), 1, 0, 4, 1, 1);
        tbl[14] = row(mk(1, 9, 10, 1, 1, 0, 0, 0, 1, 0, 1), 0, 1, 4, 2, 1);
        tbl[15] = row(mk(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0), 0, 1, 4, 3, 1);
        tbl[16] = row(mk(1, 1, 1, 1, 1, 4, 1, 0, 0, 0, 0), 0, 0, 4, 3, 1);
        tbl[17] = row(mk(1, 5, 4, 1, 0, 8, 1, 0, 0, 0, 0), 0, 0, 4, 3, 1);
        tbl[18] = row(mk(0, 8, 0, 1, 0, 10, 1, 0, 0, 0, 0), 0, 0, 4, 3, 1);
        tbl[19] = row(mk(1, 8, 0, 1, 0, 10, 1, 0, 0, 0, 0), 1, 0, 5, 3, 1);
        tbl[20] = row(mk(1, 8, 0, 1, 0, 10, 1, 0, 0, 0, 0), 0, 0, 5, 3, 1);
        tbl[21] = row(mk(1, 10, 0, 1, 0, 11, 1, 0, 0, 0, 1), 0, 0, 5, 3, 1);
        tbl[22] = row(mk(1, 10, 0, 1, 0, 12, 1, 0, 0, 0, 0), 1, 0, 6, 3, 1);

        do_reset("reset");

        for (int i = 0; i < NVEC; i++) begin
            t = $sformatf("vec%0d", i);
            step(tbl[i].in, t, h, f);
            check({t, " tbl_haz"}, h, tbl[i].haz);
            check({t, " tbl_flush"}, f, tbl[i].fl);
            check({t, " tbl_stall_cnt"}, bus.stall_cnt, tbl[i].sc);
            check({t, " tbl_flush_cnt"}, bus.flush_cnt, tbl[i].fc);
            check({t, " tbl_wdog"}, bus.wdog_err, tbl[i].wd);
        end

        // Watchdog: two back-to-back stalls without forwarding reach MAX_STALL and stick.
        do_reset("wdog reset");
        step(mk(1, 1, 1, 1, 1, 3, 1, 0, 0, 0, 0), "wdog writer", h, f);
        step(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0), "wdog stall1", h, f);
        check("wdog after 1 stall", bus.wdog_err, 0);
        step(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0), "wdog stall2", h, f);
        check("wdog after 2 stalls", bus.wdog_err, 1);
        step(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0), "wdog release", h, f);
        check("wdog release hazard", h, 0);
        step(idle, "wdog idle", h, f);
        check("wdog sticky", bus.wdog_err, 1);

        // Reset asserted in the middle of a stall drops everything at once.
        do_reset("mid reset");
        step(mk(1, 1, 1, 1, 1, 3, 1, 0, 0, 0, 0), "mid writer", h, f);
        step(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0), "mid stall1", h, f);
        @(negedge clk);
        drive(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0));
        #1;
        check("mid stall2 before reset", bus.hazard_detected, 1);
        rst = 1'b0;
        #1;
        model_reset();
        check_cleared("mid reset async");
        @(negedge clk);
        rst = 1'b1;
        step(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 0), "mid after reset", h, f);
        check("mid after reset hazard", h, 0);

        // Saturation: 20 stall cycles on a 4-bit counter stop at 15.
        do_reset("sat reset");
        for (int k = 0; k < 10; k++) begin
            step(mk(1, 0, 0, 1, 1, k + 1, 1, 0, 0, 0, 0), "sat writer", h, f);
            for (int j = 0; j < 3; j++)
                step(mk(1, k + 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "sat reader", h, f);
            if (k == 6) check("sat stall_cnt at 14", bus.stall_cnt, 14);
        end
        check("sat stall_cnt", bus.stall_cnt, CNT_MAX);

        // Randomized traffic on a small register set so dependencies are frequent.
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) do_reset("rand reset");
            rin = mk($urandom_range(3) != 0, $urandom_range(3), $urandom_range(3),
                     1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3),
                     $urandom_range(3) != 0, 1'($urandom_range(1)),
                     $urandom_range(4) == 0, $urandom_range(7) == 0, 1'($urandom_range(1)));
            step(rin, $sformatf("rand%0d", i), h, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
